// File: rtl/multi_ctl_pkg.sv
// -----------------------------------------------------------------------------
// multi_ctl_pkg
//   Shared definitions for the multi-cycle MIPS control FSM:
//   - supported opcode values (IR[31:26])
//   - state encodings S_IF..S_JMP
//   - ALU operation, ALU B-source and PC-source select constants
//   - packed control word carried from the decoder to the output stage
//   - helper that says whether an opcode is implemented
// -----------------------------------------------------------------------------
package multi_ctl_pkg;

  // Width of the state register; ten states need at least four bits.
  localparam int ST_BITS = 4;

  // Opcodes handled by the controller.
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // ALU operation (same encoding as the single-cycle controller).
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_SUB   = 2'b11;

  // ALU B operand source.
  localparam logic [1:0] ALUSRCB_RT      = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
  localparam logic [1:0] ALUSRCB_IMM_SH2 = 2'b11;

  // Next-PC source.
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Controller states. Encodings 10..15 are unused and recover to S_IF.
  typedef enum logic [ST_BITS-1:0] {
    S_IF    = 4'd0,
    S_ID    = 4'd1,
    S_MADDR = 4'd2,
    S_MRD   = 4'd3,
    S_WBL   = 4'd4,
    S_MWR   = 4'd5,
    S_EXR   = 4'd6,
    S_WBR   = 4'd7,
    S_BEQ   = 4'd8,
    S_JMP   = 4'd9
  } state_t;

  // Every datapath control in one word so it can be cleared in one step.
  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsource;
    logic       instr_done;
    logic       illegal_op;
  } ctl_t;

  // True for the five opcodes the datapath can execute.
  function automatic logic is_supported(input logic [5:0] op);
    logic ok;
    case (op)
      OP_RTYPE, OP_J, OP_BEQ, OP_LW, OP_SW: ok = 1'b1;
      default:                              ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage : multi_ctl_pkg

// File: rtl/multi_ctl_if.sv
// -----------------------------------------------------------------------------
// multi_ctl_if
//   Controller <-> multi-cycle datapath bundle.
//   Datapath to controller : opcode (IR[31:26]), mem_ready
//   Controller to datapath : PC/IR/regfile/memory enables, mux selects,
//                            instr_done and illegal_op status pulses
//   master : the controller side (drives the controls)
//   slave  : the datapath side (drives opcode and mem_ready)
// -----------------------------------------------------------------------------
interface multi_ctl_if;

  logic [5:0] opcode;
  logic       mem_ready;

  logic       pcwrite;
  logic       pcwritecond;
  logic       iord;
  logic       memread;
  logic       memwrite;
  logic       irwrite;
  logic       memtoreg;
  logic       regdst;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] aluop;
  logic [1:0] pcsource;
  logic       instr_done;
  logic       illegal_op;

  modport master (
    input  opcode, mem_ready,
    output pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
           memtoreg, regdst, regwrite, alusrca, alusrcb, aluop, pcsource,
           instr_done, illegal_op
  );

  modport slave (
    output opcode, mem_ready,
    input  pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
           memtoreg, regdst, regwrite, alusrca, alusrcb, aluop, pcsource,
           instr_done, illegal_op
  );

endinterface : multi_ctl_if

// File: rtl/multi_ctl.sv
// -----------------------------------------------------------------------------
// multi_ctl
//   Multi-cycle MIPS control FSM. Steps the shared datapath through
//   fetch / decode / execute / memory / write-back one instruction at a time
//   for R-type, LW, SW, BEQ and J. Memory states wait on mem_ready.
// Ports
//   clk    in            rising-edge clock
//   reset  in            synchronous, active-high; forces all controls to 0
//   bus    master        opcode/mem_ready in, every datapath control out
//   state  out STATE_W   current state (debug); reads S_IF while in reset
// -----------------------------------------------------------------------------
module multi_ctl
  import multi_ctl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  multi_ctl_if.master        bus,
  output logic [STATE_W-1:0] state
);

  state_t state_r;
  state_t next_state_s;
  ctl_t   dec_s;
  ctl_t   out_s;

  // State register with synchronous reset back to instruction fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_IF;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; opcode is looked at only in S_ID and S_MADDR.
  always_comb begin
    next_state_s = S_IF;
    case (state_r)
      S_IF: begin
        if (bus.mem_ready) begin
          next_state_s = S_ID;
        end else begin
          next_state_s = S_IF;
        end
      end
      S_ID: begin
        case (bus.opcode)
          OP_RTYPE:     next_state_s = S_EXR;
          OP_LW, OP_SW: next_state_s = S_MADDR;
          OP_BEQ:       next_state_s = S_BEQ;
          OP_J:         next_state_s = S_JMP;
          default:      next_state_s = S_IF;
        endcase
      end
      S_MADDR: begin
        // Opcode can only be LW or SW here; anything else abandons the
        // instruction rather than guessing a direction.
        if (bus.opcode == OP_LW) begin
          next_state_s = S_MRD;
        end else if (bus.opcode == OP_SW) begin
          next_state_s = S_MWR;
        end else begin
          next_state_s = S_IF;
        end
      end
      S_MRD: begin
        if (bus.mem_ready) begin
          next_state_s = S_WBL;
        end else begin
          next_state_s = S_MRD;
        end
      end
      S_MWR: begin
        if (bus.mem_ready) begin
          next_state_s = S_IF;
        end else begin
          next_state_s = S_MWR;
        end
      end
      S_WBL:   next_state_s = S_IF;
      S_EXR:   next_state_s = S_WBR;
      S_WBR:   next_state_s = S_IF;
      S_BEQ:   next_state_s = S_IF;
      S_JMP:   next_state_s = S_IF;
      default: next_state_s = S_IF;
    endcase
  end

  // Control decode: Moore per state, with the fetch write enables and the
  // store completion pulse held back until memory reports ready.
  always_comb begin
    dec_s = '0;
    case (state_r)
      S_IF: begin
        dec_s.memread  = 1'b1;
        dec_s.iord     = 1'b0;
        dec_s.alusrca  = 1'b0;
        dec_s.alusrcb  = ALUSRCB_FOUR;
        dec_s.aluop    = ALUOP_ADD;
        dec_s.pcsource = PCSRC_ALU;
        if (bus.mem_ready) begin
          dec_s.irwrite = 1'b1;
          dec_s.pcwrite = 1'b1;
        end else begin
          dec_s.irwrite = 1'b0;
          dec_s.pcwrite = 1'b0;
        end
      end
      S_ID: begin
        // Precompute the branch target into ALUOut while decoding.
        dec_s.alusrca    = 1'b0;
        dec_s.alusrcb    = ALUSRCB_IMM_SH2;
        dec_s.aluop      = ALUOP_ADD;
        dec_s.illegal_op = ~is_supported(bus.opcode);
      end
      S_MADDR: begin
        dec_s.alusrca = 1'b1;
        dec_s.alusrcb = ALUSRCB_IMM;
        dec_s.aluop   = ALUOP_ADD;
      end
      S_MRD: begin
        dec_s.memread = 1'b1;
        dec_s.iord    = 1'b1;
      end
      S_WBL: begin
        dec_s.regwrite   = 1'b1;
        dec_s.regdst     = 1'b0;
        dec_s.memtoreg   = 1'b1;
        dec_s.instr_done = 1'b1;
      end
      S_MWR: begin
        dec_s.memwrite   = 1'b1;
        dec_s.iord       = 1'b1;
        dec_s.instr_done = bus.mem_ready;
      end
      S_EXR: begin
        dec_s.alusrca = 1'b1;
        dec_s.alusrcb = ALUSRCB_RT;
        dec_s.aluop   = ALUOP_FUNCT;
      end
      S_WBR: begin
        dec_s.regwrite   = 1'b1;
        dec_s.regdst     = 1'b1;
        dec_s.memtoreg   = 1'b0;
        dec_s.instr_done = 1'b1;
      end
      S_BEQ: begin
        dec_s.alusrca     = 1'b1;
        dec_s.alusrcb     = ALUSRCB_RT;
        dec_s.aluop       = ALUOP_SUB;
        dec_s.pcwritecond = 1'b1;
        dec_s.pcsource    = PCSRC_ALUOUT;
        dec_s.instr_done  = 1'b1;
      end
      S_JMP: begin
        dec_s.pcwrite    = 1'b1;
        dec_s.pcsource   = PCSRC_JUMP;
        dec_s.instr_done = 1'b1;
      end
      default: begin
        dec_s = '0;
      end
    endcase
  end

  // Reset overrides decode so no write enable can fire on the abort cycle.
  always_comb begin
    if (reset) begin
      out_s = '0;
      state = STATE_W'(S_IF);
    end else begin
      out_s = dec_s;
      state = STATE_W'(state_r);
    end
  end

  assign bus.pcwrite     = out_s.pcwrite;
  assign bus.pcwritecond = out_s.pcwritecond;
  assign bus.iord        = out_s.iord;
  assign bus.memread     = out_s.memread;
  assign bus.memwrite    = out_s.memwrite;
  assign bus.irwrite     = out_s.irwrite;
  assign bus.memtoreg    = out_s.memtoreg;
  assign bus.regdst      = out_s.regdst;
  assign bus.regwrite    = out_s.regwrite;
  assign bus.alusrca     = out_s.alusrca;
  assign bus.alusrcb     = out_s.alusrcb;
  assign bus.aluop       = out_s.aluop;
  assign bus.pcsource    = out_s.pcsource;
  assign bus.instr_done  = out_s.instr_done;
  assign bus.illegal_op  = out_s.illegal_op;

endmodule : multi_ctl

// File: tb/tb_multi_ctl.sv
// -----------------------------------------------------------------------------
// tb_multi_ctl
//   Drives instructions into multi_ctl and compares every cycle's controls
//   and state against a per-instruction phase model built from the
//   controller's rules. Inputs change on the falling edge; outputs are read
//   1 time unit later, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_multi_ctl;
  import multi_ctl_pkg::*;

  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsource;
    logic       instr_done;
    logic       illegal_op;
  } vec_t;

  localparam logic [5:0] T_R   = 6'b000000;
  localparam logic [5:0] T_J   = 6'b000010;
  localparam logic [5:0] T_BEQ = 6'b000100;
  localparam logic [5:0] T_LW  = 6'b100011;
  localparam logic [5:0] T_SW  = 6'b101011;

  logic       clk;
  logic       reset;
  logic [3:0] st;
  int         total;
  int         bad;
  int         done_cnt;

  multi_ctl_if bus ();

  multi_ctl #(.STATE_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master),
    .state (st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t observed();
    vec_t o;
    o.pcwrite     = bus.pcwrite;
    o.pcwritecond = bus.pcwritecond;
    o.iord        = bus.iord;
    o.memread     = bus.memread;
    o.memwrite    = bus.memwrite;
    o.irwrite     = bus.irwrite;
    o.memtoreg    = bus.memtoreg;
    o.regdst      = bus.regdst;
    o.regwrite    = bus.regwrite;
    o.alusrca     = bus.alusrca;
    o.alusrcb     = bus.alusrcb;
    o.aluop       = bus.aluop;
    o.pcsource    = bus.pcsource;
    o.instr_done  = bus.instr_done;
    o.illegal_op  = bus.illegal_op;
    return o;
  endfunction

  function automatic logic [5:0] any_op();
    return 6'($urandom_range(0, 63));
  endfunction

  function automatic logic any_rdy();
    return 1'($urandom_range(0, 1));
  endfunction

  // One clock cycle: apply inputs, then check controls and state.
  task automatic step(input logic [5:0] opc, input logic rdy, input logic rst,
                      input state_t es, input vec_t ev, input string tag);
    vec_t o;
    @(negedge clk);
    bus.opcode    = opc;
    bus.mem_ready = rdy;
    reset         = rst;
    #1;
    o = observed();
    if (o.instr_done === 1'b1) done_cnt++;
    total++;
    assert (o === ev) else begin
      bad++;
      $error("FAIL %s ctl: got=%h exp=%h (state %0d)", tag, o, ev, st);
    end
    total++;
    assert (st === 4'(es)) else begin
      bad++;
      $error("FAIL %s state: got=%0d exp=%0d", tag, st, 4'(es));
    end
  endtask

  // Fetch with fs stalled cycles; fetch always reads at PC and adds 4.
  task automatic fetch(input int fs);
    vec_t c;
    for (int i = 0; i <= fs; i++) begin
      c = '0;
      c.memread = 1'b1;
      c.alusrcb = 2'b01;
      if (i == fs) begin
        c.irwrite = 1'b1;
        c.pcwrite = 1'b1;
      end
      step(any_op(), (i == fs), 1'b0, S_IF, c, "fetch");
    end
  endtask

  // Whole instruction: fs fetch stalls, ms data-memory stalls.
  task automatic run_instr(input logic [5:0] opc, input int fs, input int ms);
    vec_t c;
    logic legal;
    legal = (opc == T_R) || (opc == T_J) || (opc == T_BEQ) ||
            (opc == T_LW) || (opc == T_SW);
    fetch(fs);
    c = '0;
    c.alusrcb    = 2'b11;
    c.illegal_op = ~legal;
    step(opc, any_rdy(), 1'b0, S_ID, c, "decode");
    if (!legal) return;
    if (opc == T_R) begin
      c = '0; c.alusrca = 1'b1; c.aluop = 2'b10;
      step(any_op(), any_rdy(), 1'b0, S_EXR, c, "r_exec");
      c = '0; c.regwrite = 1'b1; c.regdst = 1'b1; c.instr_done = 1'b1;
      step(any_op(), any_rdy(), 1'b0, S_WBR, c, "r_wb");
    end else if (opc == T_BEQ) begin
      c = '0; c.alusrca = 1'b1; c.aluop = 2'b11; c.pcwritecond = 1'b1;
      c.pcsource = 2'b01; c.instr_done = 1'b1;
      step(any_op(), any_rdy(), 1'b0, S_BEQ, c, "beq");
    end else if (opc == T_J) begin
      c = '0; c.pcwrite = 1'b1; c.pcsource = 2'b10; c.instr_done = 1'b1;
      step(any_op(), any_rdy(), 1'b0, S_JMP, c, "jump");
    end else begin
      c = '0; c.alusrca = 1'b1; c.alusrcb = 2'b10;
      step(opc, any_rdy(), 1'b0, S_MADDR, c, "maddr");
      for (int i = 0; i <= ms; i++) begin
        c = '0;
        c.iord = 1'b1;
        if (opc == T_LW) begin
          c.memread = 1'b1;
          step(any_op(), (i == ms), 1'b0, S_MRD, c, "lw_mem");
        end else begin
          c.memwrite   = 1'b1;
          c.instr_done = (i == ms);
          step(any_op(), (i == ms), 1'b0, S_MWR, c, "sw_mem");
        end
      end
      if (opc == T_LW) begin
        c = '0; c.regwrite = 1'b1; c.memtoreg = 1'b1; c.instr_done = 1'b1;
        step(any_op(), any_rdy(), 1'b0, S_WBL, c, "lw_wb");
      end
    end
  endtask

  initial begin
    vec_t c;
    int   pick;
    int   exp_done;
    total    = 0;
    bad      = 0;
    done_cnt = 0;
    exp_done = 0;
    reset         = 1'b1;
    bus.opcode    = 6'b000000;
    bus.mem_ready = 1'b1;

    // Two cycles of reset: everything quiet, state reads S_IF.
    step(T_R, 1'b1, 1'b1, S_IF, '0, "reset0");
    step(T_LW, 1'b1, 1'b1, S_IF, '0, "reset1");

    // Directed instructions from the feature list.
    run_instr(T_R, 0, 0);   exp_done++;
    run_instr(T_LW, 0, 2);  exp_done++;
    run_instr(T_SW, 1, 1);  exp_done++;
    run_instr(T_BEQ, 0, 0); exp_done++;
    run_instr(T_J, 0, 0);   exp_done++;
    run_instr(6'b111111, 0, 0);

    // Reset landing in the middle of a stalled load.
    fetch(0);
    c = '0; c.alusrcb = 2'b11;
    step(T_LW, 1'b1, 1'b0, S_ID, c, "abort_id");
    c = '0; c.alusrca = 1'b1; c.alusrcb = 2'b10;
    step(T_LW, 1'b1, 1'b0, S_MADDR, c, "abort_maddr");
    c = '0; c.memread = 1'b1; c.iord = 1'b1;
    step(any_op(), 1'b0, 1'b0, S_MRD, c, "abort_stall");
    step(any_op(), 1'b0, 1'b1, S_IF, '0, "abort_reset");
    fetch(0);
    c = '0; c.alusrcb = 2'b11;
    step(T_J, 1'b0, 1'b0, S_ID, c, "abort_after_id");
    c = '0; c.pcwrite = 1'b1; c.pcsource = 2'b10; c.instr_done = 1'b1;
    step(any_op(), 1'b0, 1'b0, S_JMP, c, "abort_after_j");
    exp_done++;

    // Random instruction mix with random stall lengths.
    for (int n = 0; n < 40; n++) begin
      pick = $urandom_range(0, 5);
      case (pick)
        0: begin run_instr(T_R,   $urandom_range(0, 2), 0); exp_done++; end
        1: begin run_instr(T_LW,  $urandom_range(0, 2), $urandom_range(0, 3)); exp_done++; end
        2: begin run_instr(T_SW,  $urandom_range(0, 2), $urandom_range(0, 3)); exp_done++; end
        3: begin run_instr(T_BEQ, $urandom_range(0, 2), 0); exp_done++; end
        4: begin run_instr(T_J,   $urandom_range(0, 2), 0); exp_done++; end
        default: run_instr(6'b110000 | 6'($urandom_range(0, 15)), 0, 0);
      endcase
    end

    // Exactly one completion pulse per executed instruction.
    total++;
    assert (done_cnt === exp_done) else begin
      bad++;
      $error("FAIL instr_done_count: got=%0d exp=%0d", done_cnt, exp_done);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_multi_ctl
